vpu_operand_fetch: RTL and testbench



---
 rtl/vpu_operand_fetch.sv | 152 +++++++++++++++
 tb/tb_vpu_operand_fetch.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_operand_fetch.sv
// Single-beat SRAM read engine feeding one VPU source-port operand buffer.
// Optional read timeout is enabled by defining VPU_OPERAND_FETCH_TIMEOUT_EN.
module vpu_operand_fetch #(
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int SRAM_DATA_WIDTH = 256,
  parameter int RID_WIDTH       = 2,
  parameter int RID_VALUE       = 0,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic                       rvalid_i,
  input  logic [SRAM_ADDR_WIDTH-1:0] raddr_i,
  input  logic                       start_i,
  output logic                       done_o,
  output logic [SRAM_DATA_WIDTH-1:0] operand_wdata_o,
  output logic                       operand_wren_o,
  output logic                       sram_req_o,
  output logic [RID_WIDTH-1:0]       sram_rid_o,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
  output logic                       sram_reb_o,
  output logic                       sram_rlast_o,
  input  logic                       sram_ack_i,
  input  logic [SRAM_DATA_WIDTH-1:0] sram_rdata_i,
  input  logic                       sram_rvalid_i,
  output logic                       err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q;
  logic                       en_q;
  logic                       accept;
  logic                       capture;
  logic                       timeout;
  logic                       wren_q;
  logic [SRAM_DATA_WIDTH-1:0] wdata_q;

  // A new request is only taken when no SRAM transaction is in flight.
  assign accept = valid_i && (state_q == S_IDLE || state_q == S_DONE);

`ifdef VPU_OPERAND_FETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign timeout = (state_q == S_WAIT) && !sram_rvalid_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter sits at zero outside WAIT, so it is cleared on every WAIT entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout            = 1'b0;
  assign err_o              = 1'b0;
`endif

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          state_d = S_IDLE;
        end else if (start_i) begin
          state_d = en_q ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (sram_ack_i) begin
          if (sram_rvalid_i) begin
            capture = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (sram_rvalid_i) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else if (timeout) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (valid_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      en_q    <= 1'b0;
      wren_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wren_q  <= capture;
      if (accept) begin
        addr_q <= raddr_i;
        en_q   <= rvalid_i;
      end
      if (capture) begin
        wdata_q <= sram_rdata_i;
      end
    end
  end

  // SRAM request signals decode directly from the state register.
  assign sram_req_o      = (state_q == S_REQ);
  assign sram_reb_o      = !sram_req_o;
  assign sram_rlast_o    = sram_req_o;
  assign sram_addr_o     = sram_req_o ? addr_q : '0;
  assign sram_rid_o      = RID_WIDTH'(RID_VALUE);
  assign done_o          = (state_q == S_DONE);
  assign operand_wren_o  = wren_q;
  assign operand_wdata_o = wdata_q;

endmodule

// File: tb/tb_vpu_operand_fetch.sv
// Directed bench for vpu_operand_fetch: transaction-level model compared every
// cycle, plus literal expectations at key points of each scenario.
module tb_vpu_operand_fetch;

  localparam int AW  = 16;
  localparam int DW  = 256;
  localparam int RW  = 2;
  localparam int RID = 0;
  localparam int TO  = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_i, rvalid_i, start_i;
  logic [AW-1:0] raddr_i;
  logic          done_o, operand_wren_o, sram_req_o, sram_reb_o, sram_rlast_o, err_o;
  logic [DW-1:0] operand_wdata_o;
  logic [RW-1:0] sram_rid_o;
  logic [AW-1:0] sram_addr_o;
  logic          sram_ack_i, sram_rvalid_i;
  logic [DW-1:0] sram_rdata_i;

  int vectors  = 0;
  int failures = 0;
  int wren_cnt = 0;
  int req_cnt  = 0;

  always #5 clk = ~clk;

  vpu_operand_fetch #(
    .SRAM_ADDR_WIDTH(AW), .SRAM_DATA_WIDTH(DW), .RID_WIDTH(RW),
    .RID_VALUE(RID), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .rvalid_i(rvalid_i),
    .raddr_i(raddr_i), .start_i(start_i), .done_o(done_o),
    .operand_wdata_o(operand_wdata_o), .operand_wren_o(operand_wren_o),
    .sram_req_o(sram_req_o), .sram_rid_o(sram_rid_o), .sram_addr_o(sram_addr_o),
    .sram_reb_o(sram_reb_o), .sram_rlast_o(sram_rlast_o), .sram_ack_i(sram_ack_i),
    .sram_rdata_i(sram_rdata_i), .sram_rvalid_i(sram_rvalid_i), .err_o(err_o)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction model: a request is outstanding from start until data or
  // timeout; "acked" marks the data-wait phase; completion is sticky.
  logic [AW-1:0] m_addr;
  logic          m_en, m_issued, m_acked, m_done, m_wren, m_err;
  logic [DW-1:0] m_wdata;
  int            m_wait;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr <= '0; m_en <= 1'b0; m_issued <= 1'b0; m_acked <= 1'b0;
      m_done <= 1'b0; m_wren <= 1'b0; m_wdata <= '0; m_err <= 1'b0; m_wait <= 0;
    end else begin
      m_wren <= 1'b0;
      if (m_issued && !m_acked) begin
        if (sram_ack_i && sram_rvalid_i) begin
          m_wdata <= sram_rdata_i; m_wren <= 1'b1;
          m_issued <= 1'b0; m_done <= 1'b1;
        end else if (sram_ack_i) begin
          m_acked <= 1'b1; m_wait <= 0;
        end
      end else if (m_issued) begin
        if (sram_rvalid_i) begin
          m_wdata <= sram_rdata_i; m_wren <= 1'b1;
          m_issued <= 1'b0; m_acked <= 1'b0; m_done <= 1'b1;
        end
`ifdef VPU_OPERAND_FETCH_TIMEOUT_EN
        else begin
          m_wait <= m_wait + 1;
          if (m_wait + 1 == TO) begin
            m_err <= 1'b1; m_issued <= 1'b0; m_acked <= 1'b0; m_done <= 1'b1;
          end
        end
`endif
      end else if (valid_i) begin
        m_addr <= raddr_i; m_en <= rvalid_i; m_done <= 1'b0;
      end else if (!m_done && start_i) begin
        if (m_en) m_issued <= 1'b1;
        else      m_done   <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic m_req;
    m_req = m_issued && !m_acked;
    check("done",  DW'(done_o), DW'(m_done));
    check("wren",  DW'(operand_wren_o), DW'(m_wren));
    check("wdata", operand_wdata_o, m_wdata);
    check("req",   DW'(sram_req_o), DW'(m_req));
    check("reb",   DW'(sram_reb_o), DW'(!m_req));
    check("rlast", DW'(sram_rlast_o), DW'(m_req));
    check("addr",  DW'(sram_addr_o), m_req ? DW'(m_addr) : '0);
    check("rid",   DW'(sram_rid_o), DW'(RID));
    check("err",   DW'(err_o), DW'(m_err));
    if (operand_wren_o) wren_cnt++;
    if (sram_req_o) req_cnt++;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic request(input logic [AW-1:0] a, input logic en);
    valid_i = 1'b1; raddr_i = a; rvalid_i = en;
    tick();
    valid_i = 1'b0; rvalid_i = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] pat_a5, pat_5a, pat_3c;
    int            wren_base, req_base;
    pat_a5 = {32{8'hA5}};
    pat_5a = {32{8'h5A}};
    pat_3c = {32{8'h3C}};
    rst_n = 1'b0; valid_i = 1'b0; rvalid_i = 1'b0; raddr_i = '0; start_i = 1'b0;
    sram_ack_i = 1'b0; sram_rvalid_i = 1'b0; sram_rdata_i = '0;
    tick(3);
    check("rst_reb", DW'(sram_reb_o), DW'(1));
    check("rst_done", DW'(done_o), '0);
    rst_n = 1'b1;
    tick();

    // Normal fetch: ack two cycles into REQ, data three cycles after ack.
    request(16'h0123, 1'b1);
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("n_req1", DW'(sram_req_o), DW'(1));
    check("n_addr1", DW'(sram_addr_o), DW'(16'h0123));
    tick();
    check("n_addr2", DW'(sram_addr_o), DW'(16'h0123));
    sram_ack_i = 1'b1; tick(); sram_ack_i = 1'b0;
    check("n_req_off", DW'(sram_req_o), '0);
    tick(2);
    sram_rvalid_i = 1'b1; sram_rdata_i = pat_a5; tick(); sram_rvalid_i = 1'b0;
    sram_rdata_i = '0;
    check("n_wren", DW'(operand_wren_o), DW'(1));
    check("n_done", DW'(done_o), DW'(1));
    check("n_wdata", operand_wdata_o, pat_a5);
    start_i = 1'b1; tick(3); start_i = 1'b0;
    check("n_wren_once", DW'(wren_cnt), DW'(1));
    check("n_hold", operand_wdata_o, pat_a5);
    check("n_noretrig", DW'(sram_req_o), '0);

    // Unused port: no SRAM traffic, done one cycle after start.
    req_base = req_cnt;
    request(16'h0BAD, 1'b0);
    check("u_done_clr", DW'(done_o), '0);
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("u_done", DW'(done_o), DW'(1));
    tick(2);
    check("u_noreq", DW'(req_cnt - req_base), '0);

    // Ack and data on the first REQ cycle.
    request(16'h0200, 1'b1);
    start_i = 1'b1; tick(); start_i = 1'b0;
    req_base = req_cnt;
    sram_ack_i = 1'b1; sram_rvalid_i = 1'b1; sram_rdata_i = pat_5a;
    tick();
    sram_ack_i = 1'b0; sram_rvalid_i = 1'b0;
    check("s_wren", DW'(operand_wren_o), DW'(1));
    check("s_done", DW'(done_o), DW'(1));
    check("s_wdata", operand_wdata_o, pat_5a);
    check("s_req_cycles", DW'(req_cnt - req_base), DW'(1));

    // Busy ignore: valid during WAIT must not change the latched address.
    request(16'h0456, 1'b1);
    start_i = 1'b1; tick(); start_i = 1'b0;
    sram_ack_i = 1'b1; tick(); sram_ack_i = 1'b0;
    request(16'h0FFF, 1'b1);
    sram_rvalid_i = 1'b1; sram_rdata_i = pat_3c; tick(); sram_rvalid_i = 1'b0;
    check("b_done", DW'(done_o), DW'(1));
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("b_no_stale", DW'(sram_req_o), '0);
    request(16'h0789, 1'b1);
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("b_addr", DW'(sram_addr_o), DW'(16'h0789));
    sram_ack_i = 1'b1; sram_rvalid_i = 1'b1; sram_rdata_i = pat_a5; tick();
    sram_ack_i = 1'b0; sram_rvalid_i = 1'b0;

    // Asynchronous reset during WAIT, then a late response.
    request(16'h0321, 1'b1);
    start_i = 1'b1; tick(); start_i = 1'b0;
    sram_ack_i = 1'b1; tick(); sram_ack_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("r_wdata", operand_wdata_o, '0);
    check("r_reb", DW'(sram_reb_o), DW'(1));
    tick();
    rst_n = 1'b1;
    wren_base = wren_cnt;
    sram_rvalid_i = 1'b1; sram_rdata_i = pat_5a; tick(); sram_rvalid_i = 1'b0;
    tick();
    check("r_no_wren", DW'(wren_cnt - wren_base), '0);
    check("r_done", DW'(done_o), '0);

    // Missing response: timeout when enabled, indefinite WAIT otherwise.
    request(16'h0ABC, 1'b1);
    start_i = 1'b1; tick(); start_i = 1'b0;
    sram_ack_i = 1'b1; tick(); sram_ack_i = 1'b0;
    wren_base = wren_cnt;
    tick(TO - 1);
    check("t_pre_done", DW'(done_o), '0);
    check("t_pre_err", DW'(err_o), '0);
    tick();
`ifdef VPU_OPERAND_FETCH_TIMEOUT_EN
    check("t_err", DW'(err_o), DW'(1));
    check("t_done", DW'(done_o), DW'(1));
    tick(2);
    check("t_err_sticky", DW'(err_o), DW'(1));
`else
    tick(8);
    check("t_err", DW'(err_o), '0);
    check("t_stay", DW'(done_o), '0);
`endif
    check("t_no_wren", DW'(wren_cnt - wren_base), '0);
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    check("t_err_clr", DW'(err_o), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
